// File: rtl/fios_word_scheduler.sv
// Purpose : sequences the word-serial FIOS Montgomery datapath over all (i,j) word products.
// Latency : first issue one cycle after start; busy for WORD_COUNT^2 + DRAIN + 1 cycles unheld.
// Backpr. : hold_i freezes all progress (no issue, delay lines disabled); abort_i returns to idle.
//
// Ports:
//   clock_i, reset_i       - clock (posedge) and asynchronous active-high reset
//   start_i                - start a multiplication (accepted in IDLE only)
//   hold_i                 - stall; freezes state and counters
//   abort_i                - synchronous return to IDLE, highest priority
//   busy_o                 - high in RUN, DRAIN and DONE
//   issue_o                - a word product (i_idx_o, j_idx_o) is issued this cycle
//   dly_en_o               - shared enable for the datapath delay lines
//   i_idx_o, j_idx_o       - registered outer/inner word indices
//   first_j_o, last_j_o    - issue qualifiers for j==0 and j==WORD_COUNT-1
//   done_o                 - one-cycle completion pulse
module fios_word_scheduler #(
    parameter int WORD_COUNT = 8,
    parameter int DRAIN      = 4,
    localparam int IDX_W     = $clog2(WORD_COUNT)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             hold_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             issue_o,
    output logic             dly_en_o,
    output logic [IDX_W-1:0] i_idx_o,
    output logic [IDX_W-1:0] j_idx_o,
    output logic             first_j_o,
    output logic             last_j_o,
    output logic             done_o
);

    // Wide enough to hold DRAIN-1 and never zero width, even for DRAIN == 0.
    localparam int DCW = $clog2(DRAIN + 2);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] i_q;
    logic [IDX_W-1:0] j_q;
    logic [DCW-1:0]   drain_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            drain_q <= '0;
        end else if (abort_i) begin
            // Abort wins over hold and start in every state, and never pulses done.
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            drain_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        i_q     <= '0;
                        j_q     <= '0;
                    end
                end
                S_RUN: begin
                    if (!hold_i) begin
                        if (j_q == LAST_IDX) begin
                            j_q <= '0;
                            if (i_q == LAST_IDX) begin
                                // Last product issued this cycle: indices park at 0.
                                i_q <= '0;
                                if (DRAIN > 0) begin
                                    state_q <= S_DRAIN;
                                    drain_q <= DCW'(DRAIN - 1);
                                end else begin
                                    state_q <= S_DONE;
                                end
                            end else begin
                                i_q <= i_q + IDX_W'(1);
                            end
                        end else begin
                            j_q <= j_q + IDX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!hold_i) begin
                        if (drain_q == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            drain_q <= drain_q - DCW'(1);
                        end
                    end
                end
                S_DONE: begin
                    // Hold is ignored here; start seen in this cycle is dropped.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Combinational decode so that reset forces every output low immediately.
    always_comb begin
        busy_o   = 1'b0;
        issue_o  = 1'b0;
        dly_en_o = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            S_RUN: begin
                busy_o   = 1'b1;
                issue_o  = !hold_i;
                dly_en_o = !hold_i;
            end
            S_DRAIN: begin
                busy_o   = 1'b1;
                dly_en_o = !hold_i;
            end
            S_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign i_idx_o   = i_q;
    assign j_idx_o   = j_q;
    assign first_j_o = issue_o && (j_q == '0);
    assign last_j_o  = issue_o && (j_q == LAST_IDX);

endmodule

// File: tb/tb_fios_word_scheduler.sv
module tb_fios_word_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: default parameters (WORD_COUNT=8, DRAIN=4)
    logic       start_a, hold_a, abort_a;
    logic       busy_a, issue_a, dly_a, first_a, last_a, done_a;
    logic [2:0] i_a, j_a;

    // Instance B: WORD_COUNT=2, DRAIN=0
    logic       start_b, hold_b, abort_b;
    logic       busy_b, issue_b, dly_b, first_b, last_b, done_b;
    logic [0:0] i_b, j_b;

    fios_word_scheduler u_dut_a (
        .clock_i   (clk),
        .reset_i   (rst),
        .start_i   (start_a),
        .hold_i    (hold_a),
        .abort_i   (abort_a),
        .busy_o    (busy_a),
        .issue_o   (issue_a),
        .dly_en_o  (dly_a),
        .i_idx_o   (i_a),
        .j_idx_o   (j_a),
        .first_j_o (first_a),
        .last_j_o  (last_a),
        .done_o    (done_a)
    );

    fios_word_scheduler #(.WORD_COUNT(2), .DRAIN(0)) u_dut_b (
        .clock_i   (clk),
        .reset_i   (rst),
        .start_i   (start_b),
        .hold_i    (hold_b),
        .abort_i   (abort_b),
        .busy_o    (busy_b),
        .issue_o   (issue_b),
        .dly_en_o  (dly_b),
        .i_idx_o   (i_b),
        .j_idx_o   (j_b),
        .first_j_o (first_b),
        .last_j_o  (last_b),
        .done_o    (done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   i;
        int   j;
        logic first;
        logic last;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Per-cycle observation log for instance A
    logic issue_l [0:127];
    logic dly_l   [0:127];
    logic busy_l  [0:127];
    logic done_l  [0:127];
    int   i_l     [0:127];
    int   j_l     [0:127];
    int   left_after_abort;

    task automatic push_a();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                q_a.push_back('{i, j, (j == 0), (j == 7)});
    endtask

    task automatic push_b();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                q_b.push_back('{i, j, (j == 0), (j == 1)});
    endtask

    // Drives instance A cycle by cycle from a point just after a rising edge.
    // Cycle 0 carries the initial start. Expected products are queued when an
    // accepted start is driven and popped whenever issue_o is seen.
    task automatic run_a(input int ncyc, input int hold_lo, input int hold_hi,
                         input int st_x, input int st_y,
                         input int abort_c, input int restart_c);
        exp_t e;
        for (int c = 0; c < ncyc; c++) begin
            start_a = (c == 0) || (c == st_x) || (c == st_y) || (c == restart_c);
            hold_a  = (c >= hold_lo) && (c <= hold_hi);
            abort_a = (c == abort_c);
            if (c == 0 || c == restart_c) push_a();
            @(negedge clk);
            issue_l[c] = issue_a;
            dly_l[c]   = dly_a;
            busy_l[c]  = busy_a;
            done_l[c]  = done_a;
            i_l[c]     = int'(i_a);
            j_l[c]     = int'(j_a);
            n_checks++;
            if (issue_a) begin
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_a_unexpected cycle %0d: issue (%0d,%0d) with nothing expected", c, i_a, j_a);
                end else begin
                    e = q_a.pop_front();
                    if ({int'(i_a), int'(j_a), first_a, last_a} !== {e.i, e.j, e.first, e.last}) begin
                        n_fail++;
                        $display("FAIL sb_a cycle %0d: got (%0d,%0d) first=%b last=%b, want (%0d,%0d) first=%b last=%b",
                                 c, i_a, j_a, first_a, last_a, e.i, e.j, e.first, e.last);
                    end
                end
            end else if ({first_a, last_a} !== 2'b00) begin
                n_fail++;
                $display("FAIL qual_a cycle %0d: first/last=%b%b without issue, want 00", c, first_a, last_a);
            end
            if (c == abort_c) begin
                left_after_abort = q_a.size();
                q_a.delete();
            end
            @(posedge clk);
            #1;
        end
        start_a = 1'b0;
        hold_a  = 1'b0;
        abort_a = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy_a, issue_a, dly_a, i_a, j_a, first_a, last_a, done_a} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_a: outputs=%h, want 000",
                     {busy_a, issue_a, dly_a, i_a, j_a, first_a, last_a, done_a});
        end
        n_checks++;
        if ({busy_b, issue_b, dly_b, i_b, j_b, first_b, last_b, done_b} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_b: outputs=%h, want 00",
                     {busy_b, issue_b, dly_b, i_b, j_b, first_b, last_b, done_b});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [3:0] exp_v;
        run_a(75, -1, -1, -1, -1, -1, -1);
        for (int c = 0; c < 75; c++) begin
            exp_v = {(c >= 1 && c <= 64), (c >= 1 && c <= 68), (c == 69), (c >= 1 && c <= 69)};
            n_checks++;
            if ({issue_l[c], dly_l[c], done_l[c], busy_l[c]} !== exp_v) begin
                n_fail++;
                $display("FAIL basic cycle %0d: issue/dly/done/busy=%b, want %b",
                         c, {issue_l[c], dly_l[c], done_l[c], busy_l[c]}, exp_v);
            end
        end
        n_checks++;
        if (q_a.size() != 0) begin
            n_fail++;
            $display("FAIL basic_count: %0d products never issued, want 0", q_a.size());
        end
    endtask

    task automatic test_hold();
        logic [3:0] exp_v;
        run_a(80, 10, 12, -1, -1, -1, -1);
        for (int c = 0; c < 80; c++) begin
            exp_v = {((c >= 1 && c <= 9) || (c >= 13 && c <= 67)),
                     ((c >= 1 && c <= 9) || (c >= 13 && c <= 71)),
                     (c == 72), (c >= 1 && c <= 72)};
            n_checks++;
            if ({issue_l[c], dly_l[c], done_l[c], busy_l[c]} !== exp_v) begin
                n_fail++;
                $display("FAIL hold cycle %0d: issue/dly/done/busy=%b, want %b",
                         c, {issue_l[c], dly_l[c], done_l[c], busy_l[c]}, exp_v);
            end
        end
        n_checks++;
        if ({issue_l[13], i_l[13], j_l[13]} !== {1'b1, 32'sd1, 32'sd1}) begin
            n_fail++;
            $display("FAIL hold_resume: cycle 13 issue=%b (%0d,%0d), want 1 (1,1)",
                     issue_l[13], i_l[13], j_l[13]);
        end
        n_checks++;
        if (q_a.size() != 0) begin
            n_fail++;
            $display("FAIL hold_count: %0d products never issued, want 0", q_a.size());
        end
    endtask

    task automatic test_start_ignored();
        logic [3:0] exp_v;
        run_a(80, -1, -1, 5, 69, -1, -1);
        for (int c = 0; c < 80; c++) begin
            exp_v = {(c >= 1 && c <= 64), (c >= 1 && c <= 68), (c == 69), (c >= 1 && c <= 69)};
            n_checks++;
            if ({issue_l[c], dly_l[c], done_l[c], busy_l[c]} !== exp_v) begin
                n_fail++;
                $display("FAIL start_ign cycle %0d: issue/dly/done/busy=%b, want %b",
                         c, {issue_l[c], dly_l[c], done_l[c], busy_l[c]}, exp_v);
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] exp_v;
        run_a(105, -1, -1, -1, -1, 30, 31);
        n_checks++;
        if (left_after_abort != 34) begin
            n_fail++;
            $display("FAIL abort_issued: %0d products left at abort, want 34", left_after_abort);
        end
        for (int c = 0; c < 105; c++) begin
            exp_v = {((c >= 1 && c <= 30) || (c >= 32 && c <= 95)),
                     ((c >= 1 && c <= 30) || (c >= 32 && c <= 99)),
                     (c == 100),
                     ((c >= 1 && c <= 30) || (c >= 32 && c <= 100))};
            n_checks++;
            if ({issue_l[c], dly_l[c], done_l[c], busy_l[c]} !== exp_v) begin
                n_fail++;
                $display("FAIL abort cycle %0d: issue/dly/done/busy=%b, want %b",
                         c, {issue_l[c], dly_l[c], done_l[c], busy_l[c]}, exp_v);
            end
        end
        n_checks++;
        if ({i_l[31], j_l[31], i_l[32], j_l[32]} !== {32'sd0, 32'sd0, 32'sd0, 32'sd0}) begin
            n_fail++;
            $display("FAIL abort_idx: cycle31 (%0d,%0d) cycle32 (%0d,%0d), want (0,0) (0,0)",
                     i_l[31], j_l[31], i_l[32], j_l[32]);
        end
        n_checks++;
        if (q_a.size() != 0) begin
            n_fail++;
            $display("FAIL abort_count: %0d products never issued after restart, want 0", q_a.size());
        end
    endtask

    task automatic test_small();
        exp_t       e;
        logic [3:0] exp_v;
        for (int c = 0; c < 8; c++) begin
            start_b = (c == 0);
            if (c == 0) push_b();
            @(negedge clk);
            exp_v = {(c >= 1 && c <= 4), (c >= 1 && c <= 4), (c == 5), (c >= 1 && c <= 5)};
            n_checks++;
            if ({issue_b, dly_b, done_b, busy_b} !== exp_v) begin
                n_fail++;
                $display("FAIL small cycle %0d: issue/dly/done/busy=%b, want %b",
                         c, {issue_b, dly_b, done_b, busy_b}, exp_v);
            end
            if (issue_b) begin
                n_checks++;
                if (q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_b_unexpected cycle %0d: issue (%0d,%0d)", c, i_b, j_b);
                end else begin
                    e = q_b.pop_front();
                    if ({int'(i_b), int'(j_b), first_b, last_b} !== {e.i, e.j, e.first, e.last}) begin
                        n_fail++;
                        $display("FAIL sb_b cycle %0d: got (%0d,%0d) first=%b last=%b, want (%0d,%0d) first=%b last=%b",
                                 c, i_b, j_b, first_b, last_b, e.i, e.j, e.first, e.last);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        start_b = 1'b0;
        n_checks++;
        if (q_b.size() != 0) begin
            n_fail++;
            $display("FAIL small_count: %0d products never issued, want 0", q_b.size());
        end
        // Abort together with start in IDLE must keep the block idle.
        start_b = 1'b1;
        abort_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        abort_b = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy_b, issue_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_blocks_start: busy/issue=%b, want 00", {busy_b, issue_b});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        n_checks++;
        if ({busy_a, issue_a} !== 2'b11) begin
            n_fail++;
            $display("FAIL areset_pre: busy/issue=%b, want 11", {busy_a, issue_a});
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy_a, issue_a, dly_a, i_a, j_a, first_a, last_a, done_a} !== 12'h000) begin
            n_fail++;
            $display("FAIL areset_now: outputs=%h, want 000",
                     {busy_a, issue_a, dly_a, i_a, j_a, first_a, last_a, done_a});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({busy_a, issue_a, dly_a, done_a} !== 4'b0000) begin
                n_fail++;
                $display("FAIL areset_idle %0d: busy/issue/dly/done=%b, want 0000",
                         c, {busy_a, issue_a, dly_a, done_a});
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        hold_a  = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        hold_b  = 1'b0;
        abort_b = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_start_ignored();
        test_abort();
        test_small();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fios_word_scheduler.md
Name: fios_word_scheduler

Overview:
Sequences the word-serial FIOS Montgomery datapath. On start, it walks the outer index i and inner index j over all WORD_COUNT x WORD_COUNT word products. It drives the enable shared by the pipeline's delay lines and operand word-select indices, then drains the pipeline and reports completion. It sits between the top-level multiplier control and the DSP/delay-line datapath.

Parameters:
WORD_COUNT, 8, number of operand words per operand; legal range is at least 2.
DRAIN, 4, pipeline-flush cycles after the last issue; 0 is legal.
IDX_W (localparam, not overridable), $clog2(WORD_COUNT), width of the index outputs.

Ports:
clock_i  input  1  clock; everything is posedge.
reset_i  input  1  asynchronous, active-high reset.
start_i  input  1  request a new multiplication; sampled only in IDLE.
hold_i  input  1  stall; freezes progress while high.
abort_i  input  1  synchronous abort back to IDLE.
busy_o  output  1  high in RUN, DRAIN and DONE.
issue_o  output  1  a word product (i,j) is issued this cycle.
dly_en_o  output  1  enable for all datapath delay lines.
i_idx_o  output  IDX_W  outer word index.
j_idx_o  output  IDX_W  inner word index.
first_j_o  output  1  issue_o && j==0; starts a new outer iteration.
last_j_o  output  1  issue_o && j==WORD_COUNT-1.
done_o  output  1  one-cycle completion pulse.

Behaviour:
- State, i, j and drain count are registered. On reset_i=1 they clear asynchronously: state=IDLE, i=j=0, drain count=0.
- Reset values of outputs: busy_o=0, issue_o=0, dly_en_o=0, i_idx_o=0, j_idx_o=0, first_j_o=0, last_j_o=0, done_o=0.
- Outputs decode combinationally from state, counters and hold_i. i_idx_o and j_idx_o show the registered counters at all times.
- IDLE: if start_i=1, go to RUN with i=j=0. The first issue happens in the next cycle.
- RUN:
  - issue_o = dly_en_o = !hold_i.
  - On a non-held cycle, j increments. When j==WORD_COUNT-1, j wraps to 0 and i increments.
  - On a non-held cycle with i==j==WORD_COUNT-1: if DRAIN>0, go to DRAIN with drain count=DRAIN-1; otherwise go to DONE. i and j return to 0.
- DRAIN:
  - issue_o=0; dly_en_o=!hold_i.
  - On a non-held cycle, if drain count==0 go to DONE, otherwise decrement.
- DONE: done_o=1, busy_o=1, issue_o=0, dly_en_o=0. Go to IDLE next cycle unconditionally; hold_i is ignored.
- hold_i=1 freezes state and all counters. issue_o and dly_en_o are 0; busy_o is unchanged.
- start_i outside IDLE is ignored and not queued. start_i in the DONE cycle is also ignored; a new start is accepted from IDLE only.
- abort_i=1 in any state returns to IDLE with i=j=0 next cycle, with no done_o pulse. abort_i has priority over hold_i and start_i. abort_i in IDLE blocks start_i in that cycle.
- reset_i mid-operation returns to IDLE immediately; no done_o pulse.
- Unheld timing (start sampled at cycle 0): RUN occupies cycles 1..WORD_COUNT², DRAIN the next DRAIN cycles, DONE one cycle. Total busy = WORD_COUNT² + DRAIN + 1 cycles.
- Each cycle of hold_i in RUN/DRAIN extends the total by exactly one cycle.

Test Plan:
- Defaults, start at cycle 0, no hold:
  - issue_o is high in cycles 1..64.
  - (i,j) goes (0,0),(0,1)..(0,7),(1,0)..(7,7).
  - first_j_o is high in cycles 1,9,..,57; last_j_o in cycles 8,16,..,64.
  - dly_en_o is high in cycles 1..68; done_o only in cycle 69; busy_o in cycles 1..69.
- hold_i high in cycles 10..12: no issue in those cycles; (1,1) issues in cycle 13; done_o moves to cycle 72.
- start_i pulsed in cycles 5 and 69 during the first run: both are ignored; no second run occurs and busy_o=0 from cycle 70.
- abort_i in cycle 30: IDLE in cycle 31 with indices 0 and no done_o. start_i in cycle 31 restarts, with (0,0) issued in cycle 32.
- reset_i asserted asynchronously mid-RUN (between edges): all outputs go to 0 without waiting for a clock edge. After release, the block stays idle until start_i.
- WORD_COUNT=2, DRAIN=0: issues (0,0),(0,1),(1,0),(1,1) in cycles 1..4; done_o in cycle 5; no DRAIN cycles.
